fetch_stage: RTL and testbench

Instruction fetch stage: the producer of the 32-bit instruction word consumed by the decode stage. It holds the program counter and issues word reads to instruction memory over a request/acknowledge plus response-valid handshake, with at most one request outstanding. It presents {instruction, PC, valid} to decode, holds that output under stall, and flushes and re-fetches on a branch or jump redirect from execute.

---
 rtl/fetch_stage.sv | 172 +++++++++++++++++
 tb/tb_fetch_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC and issues one-outstanding word reads to
// instruction memory. It presents {instr, pc, valid} to decode and handles stalls and redirects.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_in_stall,
  input  logic        f_in_redirect,
  input  logic [31:0] f_in_redirect_pc,
  output logic        f_out_imem_req,
  output logic [31:0] f_out_imem_addr,
  input  logic        f_in_imem_ack,
  input  logic        f_in_imem_rvalid,
  input  logic [31:0] f_in_imem_rdata,
  output logic [31:0] f_out_instr,
  output logic [31:0] f_out_pc,
  output logic        f_out_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        discard_q, discard_d;
  logic        req_q, req_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        out_valid_q, out_valid_d;

  logic        out_free;
  logic        load_out;
  logic [31:0] load_instr;
  logic [31:0] load_pc;

  // Next-state, PC, buffer and output-register computation.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    discard_d   = discard_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    out_valid_d = out_valid_q;
    load_out    = 1'b0;
    load_instr  = f_in_imem_rdata;
    load_pc     = pc_q;
    out_free    = (!out_valid_q) || (!f_in_stall);

    if (f_in_redirect) begin
      // Redirect beats stall: the output bubble and new PC are unconditional.
      pc_d        = f_in_redirect_pc & ~32'd3;
      out_valid_d = 1'b0;
      out_instr_d = NOP_INSTR;
      discard_d   = 1'b0;
      case (state_q)
        S_WAIT: begin
          if (f_in_imem_rvalid) begin
            state_d = S_REQ;
          end else begin
            state_d   = S_WAIT;
            discard_d = 1'b1;
          end
        end
        S_REQ: begin
          if (f_in_imem_ack) begin
            state_d   = S_WAIT;
            discard_d = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_d = S_REQ;
        S_REQ: begin
          if (f_in_imem_ack) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (!f_in_imem_rvalid) begin
            state_d = S_WAIT;
          end else if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else if (out_free) begin
            load_out = 1'b1;
            pc_d     = pc_q + 32'd4;
            state_d  = S_REQ;
          end else begin
            buf_instr_d = f_in_imem_rdata;
            buf_pc_d    = pc_q;
            pc_d        = pc_q + 32'd4;
            state_d     = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!f_in_stall) begin
            load_out   = 1'b1;
            load_instr = buf_instr_q;
            load_pc    = buf_pc_q;
            state_d    = S_REQ;
          end else begin
            state_d = S_HOLD;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (load_out) begin
        out_instr_d = load_instr;
        out_pc_d    = load_pc;
        out_valid_d = 1'b1;
      end else if (!f_in_stall) begin
        out_instr_d = NOP_INSTR;
        out_valid_d = 1'b0;
      end else begin
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        out_valid_d = out_valid_q;
      end
    end

    req_d = (state_d == S_REQ);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      discard_q   <= 1'b0;
      req_q       <= 1'b0;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= RESET_PC;
      out_instr_q <= NOP_INSTR;
      out_pc_q    <= RESET_PC;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      discard_q   <= discard_d;
      req_q       <= req_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign f_out_imem_req  = req_q;
  assign f_out_imem_addr = pc_q;
  assign f_out_instr     = out_instr_q;
  assign f_out_pc        = out_pc_q;
  assign f_out_valid     = out_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: main instance at RESET_PC=0x100, second instance
// at RESET_PC=0xFFFFFFFC for PC wrap-around.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] K   = 32'hA5A5_A5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, redir;
  logic [31:0] redir_pc;
  logic        req, ack, rvalid;
  logic [31:0] addr, rdata, instr, pc;
  logic        valid;

  logic        w_rst, w_ack, w_rvalid;
  logic [31:0] w_rdata, w_addr, w_instr, w_pc;
  logic        w_req, w_valid;

  int n_checks = 0;
  int n_errors = 0;

  logic        pend;
  logic [31:0] pend_addr;

  fetch_stage #(.RESET_PC(32'h0000_0100), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .f_in_stall(stall), .f_in_redirect(redir),
    .f_in_redirect_pc(redir_pc), .f_out_imem_req(req), .f_out_imem_addr(addr),
    .f_in_imem_ack(ack), .f_in_imem_rvalid(rvalid), .f_in_imem_rdata(rdata),
    .f_out_instr(instr), .f_out_pc(pc), .f_out_valid(valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_wrap (
    .clk(clk), .rst(w_rst), .f_in_stall(1'b0), .f_in_redirect(1'b0),
    .f_in_redirect_pc(32'h0000_0000), .f_out_imem_req(w_req), .f_out_imem_addr(w_addr),
    .f_in_imem_ack(w_ack), .f_in_imem_rvalid(w_rvalid), .f_in_imem_rdata(w_rdata),
    .f_out_instr(w_instr), .f_out_pc(w_pc), .f_out_valid(w_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait memory: ack mirrors req when allowed, response held back when en_resp=0.
  task automatic mem_step(input bit en_ack, input bit en_resp);
    ack    = en_ack & req;
    rvalid = en_resp & pend;
    rdata  = pend_addr ^ K;
    if (en_resp) pend = 1'b0;
    if (ack) begin
      pend      = 1'b1;
      pend_addr = addr;
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redir = 1'b0; redir_pc = 32'h0;
    ack = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    w_rst = 1'b1; w_ack = 1'b0; w_rvalid = 1'b0; w_rdata = 32'h0;
    pend = 1'b0; pend_addr = 32'h0;
    tick(); tick();

    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_addr", addr, 32'h100);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_pc", pc, 32'h100);

    rst = 1'b0;
    tick();
    check("first_req", {31'd0, req}, 32'd1);
    check("first_addr", addr, 32'h100);

    // Streaming at one instruction per two cycles
    mem_step(1'b1, 1'b1);
    check("wait_req", {31'd0, req}, 32'd0);
    mem_step(1'b1, 1'b1);
    check("i0_valid", {31'd0, valid}, 32'd1);
    check("i0_pc", pc, 32'h100);
    check("i0_instr", instr, 32'h100 ^ K);
    check("i0_next_addr", addr, 32'h104);
    check("i0_next_req", {31'd0, req}, 32'd1);
    mem_step(1'b1, 1'b1);
    check("gap_valid", {31'd0, valid}, 32'd0);
    check("gap_instr", instr, NOP);
    mem_step(1'b1, 1'b1);
    check("i1_pc", pc, 32'h104);
    check("i1_instr", instr, 32'h104 ^ K);
    mem_step(1'b1, 1'b1);
    mem_step(1'b1, 1'b1);
    check("i2_valid", {31'd0, valid}, 32'd1);
    check("i2_pc", pc, 32'h108);
    check("i2_instr", instr, 32'h108 ^ K);

    // Four stalled cycles: response lands in the second and is buffered
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_step(1'b1, 1'b1);
      check("stall_valid", {31'd0, valid}, 32'd1);
      check("stall_pc", pc, 32'h108);
      check("stall_instr", instr, 32'h108 ^ K);
      check("stall_req", {31'd0, req}, 32'd0);
    end
    stall = 1'b0;
    mem_step(1'b1, 1'b1);
    check("release_valid", {31'd0, valid}, 32'd1);
    check("release_pc", pc, 32'h10C);
    check("release_instr", instr, 32'h10C ^ K);
    check("release_req", {31'd0, req}, 32'd1);
    check("release_addr", addr, 32'h110);

    // Redirect while waiting; late response must be discarded
    mem_step(1'b1, 1'b1);
    redir = 1'b1; redir_pc = 32'h2000;
    mem_step(1'b1, 1'b0);
    redir = 1'b0;
    check("redir_wait_valid", {31'd0, valid}, 32'd0);
    check("redir_wait_req", {31'd0, req}, 32'd0);
    mem_step(1'b1, 1'b0);
    check("redir_wait2_req", {31'd0, req}, 32'd0);
    mem_step(1'b1, 1'b1);
    check("discard_valid", {31'd0, valid}, 32'd0);
    check("discard_req", {31'd0, req}, 32'd1);
    check("discard_addr", addr, 32'h2000);
    mem_step(1'b1, 1'b1);
    mem_step(1'b1, 1'b1);
    check("tgt_valid", {31'd0, valid}, 32'd1);
    check("tgt_pc", pc, 32'h2000);
    check("tgt_instr", instr, 32'h2000 ^ K);

    // Redirect under stall with the buffer occupied
    stall = 1'b1;
    mem_step(1'b1, 1'b1);
    mem_step(1'b1, 1'b1);
    check("hold_valid", {31'd0, valid}, 32'd1);
    check("hold_pc", pc, 32'h2000);
    check("hold_req", {31'd0, req}, 32'd0);
    redir = 1'b1; redir_pc = 32'h3002;
    mem_step(1'b1, 1'b1);
    redir = 1'b0; stall = 1'b0;
    check("redir_hold_valid", {31'd0, valid}, 32'd0);
    check("redir_hold_instr", instr, NOP);
    check("redir_hold_req", {31'd0, req}, 32'd1);
    check("redir_hold_addr", addr, 32'h3000);
    mem_step(1'b1, 1'b1);
    check("buf_dropped_valid", {31'd0, valid}, 32'd0);
    mem_step(1'b1, 1'b1);
    check("t3_valid", {31'd0, valid}, 32'd1);
    check("t3_pc", pc, 32'h3000);
    check("t3_instr", instr, 32'h3000 ^ K);

    // Reset while a request is in flight
    stall = 1'b1;
    mem_step(1'b1, 1'b1);
    check("pre_rst_valid", {31'd0, valid}, 32'd1);
    rst = 1'b1; stall = 1'b0; pend = 1'b0;
    mem_step(1'b0, 1'b1);
    check("mid_rst_req", {31'd0, req}, 32'd0);
    check("mid_rst_addr", addr, 32'h100);
    check("mid_rst_valid", {31'd0, valid}, 32'd0);
    check("mid_rst_instr", instr, NOP);
    check("mid_rst_pc", pc, 32'h100);
    rst = 1'b0;
    mem_step(1'b1, 1'b1);
    check("post_rst_req", {31'd0, req}, 32'd1);
    check("post_rst_addr", addr, 32'h100);

    // PC wrap-around on the second instance
    w_rst = 1'b0;
    tick();
    check("wrap_req0", {31'd0, w_req}, 32'd1);
    check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    w_ack = 1'b1;
    tick();
    w_ack = 1'b0; w_rvalid = 1'b1; w_rdata = 32'hDEAD_BEEF;
    tick();
    w_rvalid = 1'b0;
    check("wrap_valid", {31'd0, w_valid}, 32'd1);
    check("wrap_pc", w_pc, 32'hFFFF_FFFC);
    check("wrap_instr", w_instr, 32'hDEAD_BEEF);
    check("wrap_req1", {31'd0, w_req}, 32'd1);
    check("wrap_addr1", w_addr, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
